// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I/RV64I decode stage, 2-entry skid buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN         = 32,
  parameter int ENABLE_ZICSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [11:0]     out_func12,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_fmt,
  output logic            out_invalid
);

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_IMM      = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  localparam logic [6:0] FMT_R = 7'b0000001;
  localparam logic [6:0] FMT_I = 7'b0000010;
  localparam logic [6:0] FMT_S = 7'b0000100;
  localparam logic [6:0] FMT_B = 7'b0001000;
  localparam logic [6:0] FMT_U = 7'b0010000;
  localparam logic [6:0] FMT_J = 7'b0100000;
  localparam logic [6:0] FMT_Z = 7'b1000000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [11:0]     func12;
    logic [XLEN-1:0] imm;
    logic [6:0]      fmt;
    logic            invalid;
  } dec_t;

  dec_t       decoded;
  dec_t       main_q, main_d;
  dec_t       skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q;
  logic [6:0] fmt_match;
  logic       illegal;
  logic       accept;
  logic       drain;
  logic       main_free;

  always_comb begin
    fmt_match = '0;
    case (in_inst[6:2])
      OP_OP:                                   fmt_match = FMT_R;
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR:   fmt_match = FMT_I;
      OP_STORE:                                fmt_match = FMT_S;
      OP_BRANCH:                               fmt_match = FMT_B;
      OP_AUIPC, OP_LUI:                        fmt_match = FMT_U;
      OP_JAL:                                  fmt_match = FMT_J;
      OP_SYSTEM: fmt_match = (ENABLE_ZICSR != 0) ? FMT_Z : 7'b0000000;
      default:                                 fmt_match = '0;
    endcase

    illegal = (fmt_match == 7'b0000000) || (in_inst[1:0] != 2'b11) ||
              ((in_inst[6:2] == OP_JALR) && (in_inst[14:12] != 3'b000));

    decoded         = '0;
    decoded.pc      = in_pc;
    decoded.opcode  = in_inst[6:2];
    decoded.rd      = in_inst[11:7];
    decoded.rs1     = in_inst[19:15];
    decoded.rs2     = in_inst[24:20];
    decoded.func3   = in_inst[14:12];
    decoded.func7   = in_inst[31:25];
    decoded.func12  = in_inst[31:20];
    decoded.invalid = illegal;
    decoded.fmt     = illegal ? 7'b0000000 : fmt_match;

    // Illegal encodings keep imm at zero so execute never sees garbage.
    if (!illegal) begin
      case (fmt_match)
        FMT_I: decoded.imm = XLEN'($signed(in_inst[31:20]));
        FMT_S: decoded.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        FMT_B: decoded.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                            in_inst[11:8], 1'b0}));
        FMT_U: decoded.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
        FMT_J: decoded.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                            in_inst[30:21], 1'b0}));
        FMT_Z: decoded.imm = XLEN'(in_inst[19:15]);
        default: decoded.imm = '0;
      endcase
    end
  end

  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid_q && out_ready;
  assign main_free = !out_valid_q || drain;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // The skid entry is older than anything arriving now, so it goes first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = decoded;
      end else begin
        out_valid_d = accept;
        if (accept) main_d = decoded;
      end
    end else if (accept) begin
      skid_d       = decoded;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_func3   = main_q.func3;
  assign out_func7   = main_q.func7;
  assign out_func12  = main_q.func12;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_invalid = main_q.invalid;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Table-driven, scoreboarded bench for decode_stage (RV32+Zicsr
//               and RV64 without Zicsr instances sharing one input stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'h0, in_pc};

  logic        in_ready, out_valid, out_invalid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_opcode, out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7, out_fmt;
  logic [11:0] out_func12;

  logic        b_in_ready, b_out_valid, b_out_invalid;
  logic [63:0] b_out_pc, b_out_imm;
  logic [4:0]  b_out_opcode, b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_func3;
  logic [6:0]  b_out_func7, b_out_fmt;
  logic [11:0] b_out_func12;

  decode_stage #(.XLEN(32), .ENABLE_ZICSR(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_func3(out_func3), .out_func7(out_func7),
    .out_func12(out_func12), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_invalid(out_invalid)
  );

  decode_stage #(.XLEN(64), .ENABLE_ZICSR(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_func3(b_out_func3), .out_func7(b_out_func7),
    .out_func12(b_out_func12), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_invalid(b_out_invalid)
  );

  localparam logic [6:0] F_R = 7'h01, F_I = 7'h02, F_S = 7'h04, F_B = 7'h08;
  localparam logic [6:0] F_U = 7'h10, F_J = 7'h20, F_Z = 7'h40, F_0 = 7'h00;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  fmt;
    logic [63:0] imm;
    logic        inv;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [6:0]  fmtb;
    logic [63:0] immb;
    logic        invb;
  } vec_t;

  vec_t tbl[14];
  vec_t cur;
  vec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] inst, input logic [6:0] fmt,
                              input logic [63:0] imm, input logic inv,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic csr);
    vec_t v;
    v.inst = inst; v.pc = '0; v.fmt = fmt; v.imm = imm; v.inv = inv;
    v.rd = rd; v.rs1 = rs1;
    v.fmtb = csr ? F_0 : fmt;
    v.immb = csr ? 64'h0 : imm;
    v.invb = csr ? 1'b1 : inv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin : mon
    vec_t e;
    logic [31:0] ins;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
        end else begin
          e = q.pop_front();
          ins = e.inst;
          chk("pc",      64'(out_pc),      64'(e.pc));
          chk("opcode",  64'(out_opcode),  64'(ins[6:2]));
          chk("rd",      64'(out_rd),      64'(e.rd));
          chk("rs1",     64'(out_rs1),     64'(e.rs1));
          chk("rs2",     64'(out_rs2),     64'(ins[24:20]));
          chk("func3",   64'(out_func3),   64'(ins[14:12]));
          chk("func7",   64'(out_func7),   64'(ins[31:25]));
          chk("func12",  64'(out_func12),  64'(ins[31:20]));
          chk("fmt",     64'(out_fmt),     64'(e.fmt));
          chk("imm",     64'(out_imm),     64'(e.imm[31:0]));
          chk("invalid", 64'(out_invalid), 64'(e.inv));
          chk("b_valid", 64'(b_out_valid), 64'd1);
          chk("b_pc",    b_out_pc,         64'(e.pc));
          chk("b_fmt",   64'(b_out_fmt),   64'(e.fmtb));
          chk("b_imm",   b_out_imm,        e.immb);
          chk("b_inv",   64'(b_out_invalid), 64'(e.invb));
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
  end

  task automatic send(input vec_t v, input logic [31:0] pc);
    cur = v;
    cur.pc = pc;
    in_inst = v.inst;
    in_pc = pc;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout: got no in_ready expected accept of pc %h", pc);
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(32'hFFF00093, F_I, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5'd1,  5'd0, 1'b0);
    tbl[1]  = mk(32'h123452B7, F_U, 64'h0000000012345000, 1'b0, 5'd5,  5'd8, 1'b0);
    tbl[2]  = mk(32'h008000EF, F_J, 64'h0000000000000008, 1'b0, 5'd1,  5'd0, 1'b0);
    tbl[3]  = mk(32'hFE000EE3, F_B, 64'hFFFFFFFFFFFFFFFC, 1'b0, 5'd29, 5'd0, 1'b0);
    tbl[4]  = mk(32'h00000000, F_0, 64'h0,                1'b1, 5'd0,  5'd0, 1'b0);
    tbl[5]  = mk(32'h00009067, F_0, 64'h0,                1'b1, 5'd0,  5'd1, 1'b0);
    tbl[6]  = mk(32'h30002573, F_Z, 64'h0,                1'b0, 5'd10, 5'd0, 1'b1);
    tbl[7]  = mk(32'hFE20AC23, F_S, 64'hFFFFFFFFFFFFFFF8, 1'b0, 5'd24, 5'd1, 1'b0);
    tbl[8]  = mk(32'h002081B3, F_R, 64'h0,                1'b0, 5'd3,  5'd1, 1'b0);
    tbl[9]  = mk(32'hFFF00090, F_0, 64'h0,                1'b1, 5'd1,  5'd0, 1'b0);
    tbl[10] = mk(32'h80000517, F_U, 64'hFFFFFFFF80000000, 1'b0, 5'd10, 5'd0, 1'b0);
    tbl[11] = mk(32'h3002D073, F_Z, 64'h5,                1'b0, 5'd0,  5'd5, 1'b1);
    tbl[12] = mk(32'h00008067, F_I, 64'h0,                1'b0, 5'd0,  5'd1, 1'b0);
    tbl[13] = mk(32'h7FF3A303, F_I, 64'h00000000000007FF, 1'b0, 5'd6,  5'd7, 1'b0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; cur = tbl[0];
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    chk("rst_out_fmt",   64'(out_fmt),   64'd0);
    chk("rst_invalid",   64'(out_invalid), 64'd0);
    rst = 1'b0;
    tick();

    // One-cycle latency on the first accepted instruction.
    out_ready = 1'b1;
    send(tbl[0], 32'h0000_0040);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_pc",    64'(out_pc),    64'h40);

    for (int i = 0; i < 14; i++) send(tbl[i], 32'h1000 + 32'(i * 4));
    repeat (3) tick();
    chk("table_drained", 64'(q.size()), 64'd0);

    // Backpressure: two accepted, third held off, then in-order drain.
    out_ready = 1'b0;
    send(tbl[0], 32'd0);
    send(tbl[0], 32'd4);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_pc_hold",  64'(out_pc),   64'd0);
    cur = tbl[0]; cur.pc = 32'd8;
    in_inst = tbl[0].inst; in_pc = 32'd8; in_valid = 1'b1;
    repeat (2) tick();
    chk("bp_still_full",  64'(in_ready), 64'd0);
    chk("bp_hold_pc",     64'(out_pc),   64'd0);
    chk("bp_hold_imm",    64'(out_imm),  64'hFFFFFFFF);
    chk("bp_hold_valid",  64'(out_valid), 64'd1);
    fork
      begin
        send(tbl[0], 32'd8);
        send(tbl[0], 32'd12);
      end
      begin
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_stream_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    tick();
    chk("bp_drained", 64'(q.size()), 64'd0);
    chk("bp_idle",    64'(out_valid), 64'd0);

    // Flush with both entries full.
    out_ready = 1'b0;
    send(tbl[1], 32'h100);
    send(tbl[1], 32'h104);
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_inst = tbl[2].inst; in_pc = 32'h108;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    send(tbl[2], 32'h10C);
    chk("fl_next_valid", 64'(out_valid), 64'd1);
    chk("fl_next_pc",    64'(out_pc),    64'h10C);
    tick();
    chk("fl_alone", 64'(out_valid), 64'd0);

    // Flush discards an input offered while the stage could accept it.
    out_ready = 1'b0;
    send(tbl[4], 32'h300);
    flush = 1'b1; in_valid = 1'b1; in_inst = tbl[0].inst; in_pc = 32'h304;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("fl2_discarded", 64'(out_valid), 64'd0);

    // Reset mid-transfer with both entries full.
    send(tbl[3], 32'h200);
    send(tbl[3], 32'h204);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("mr_out_valid", 64'(out_valid),   64'd0);
    chk("mr_in_ready",  64'(in_ready),    64'd1);
    chk("mr_out_pc",    64'(out_pc),      64'd0);
    chk("mr_out_imm",   64'(out_imm),     64'd0);
    chk("mr_out_fmt",   64'(out_fmt),     64'd0);
    chk("mr_out_rd",    64'(out_rd),      64'd0);
    chk("mr_func12",    64'(out_func12),  64'd0);
    chk("mr_b_imm",     b_out_imm,        64'd0);
    repeat (2) tick();
    chk("end_queue_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
